core_clkgen: RTL



---
 rtl/core_clk_pkg.sv | 18 +
 rtl/core_clkgen_ch.sv | 85 ++++++++
 rtl/core_clkgen.sv | 57 +++++
 3 files changed

// File: rtl/core_clk_pkg.sv
// core_clk_pkg
// Shared constants and helpers for the core clock generator.
//   CNT_W_DEF  : default width of each channel's counter and divisor field
//   SRAM_DIV   : reset divisor for the SRAM channel (half-period 1 -> clk/2)
//   PIPE_DIV   : reset divisor for the pipeline channel (half-period 10 -> clk/20)
//   ch_idx_w() : width of a channel index, never less than one bit
package core_clk_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int SRAM_DIV  = 0;
    localparam int PIPE_DIV  = 9;

    // A single-channel build still needs a one-bit index port.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/core_clkgen_ch.sv
// core_clkgen_ch
// One divided-clock channel: counter, active/pending divisor, output and tick.
// Ports:
//   clk      in   core clock, rising edge
//   rst      in   synchronous active-high reset
//   en       in   run enable; low holds the channel idle and low
//   sync     in   phase-align pulse; restarts the channel from zero
//   we       in   divisor write strobe for this channel
//   wdiv     in   divisor to queue; half-period is wdiv+1 cycles
//   pending  out  a queued divisor has not been applied yet
//   clk_out  out  registered 50% duty divided clock
//   tick     out  high in the first cycle clk_out is high
module core_clkgen_ch
    import core_clk_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEF_DIV = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [CNT_W-1:0] wdiv,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cur_div;
    logic [CNT_W-1:0] pend_div;
    logic             pend;
    logic             out_q;
    logic             tick_q;
    logic             at_end;

    assign at_end = (cnt == cur_div);

    // Counter, output toggle and divisor hand-over. A queued divisor only
    // replaces the active one on the falling toggle (or while idle), so a
    // high phase always runs its full length. The write is evaluated last:
    // when it collides with an apply, the older queued value is the one
    // applied and the new value stays queued for the next boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            out_q    <= 1'b0;
            tick_q   <= 1'b0;
            cur_div  <= DEF_DIV;
            pend_div <= DEF_DIV;
            pend     <= 1'b0;
        end else begin
            if (sync || !en) begin
                cnt    <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
                if (pend) begin
                    cur_div <= pend_div;
                    pend    <= 1'b0;
                end
            end else if (at_end) begin
                cnt    <= '0;
                out_q  <= ~out_q;
                tick_q <= ~out_q;
                if (out_q && pend) begin
                    cur_div <= pend_div;
                    pend    <= 1'b0;
                end
            end else begin
                cnt    <= cnt + 1'b1;
                tick_q <= 1'b0;
            end
            if (we) begin
                pend_div <= wdiv;
                pend     <= 1'b1;
            end
        end
    end

    assign pending = pend;
    assign clk_out = out_q;
    assign tick    = tick_q;

endmodule

// File: rtl/core_clkgen.sv
// core_clkgen
// Multi-channel clock-enable and divided-clock generator for the core.
// Ports:
//   clk          in   core input clock
//   rst          in   synchronous active-high reset
//   ch_en        in   per-channel run enable
//   sync         in   single-cycle phase-align pulse for all channels
//   cfg_we       in   divisor write strobe
//   cfg_ch       in   channel index for the write; out-of-range is ignored
//   cfg_div      in   new divisor, half-period = cfg_div+1 cycles
//   cfg_pending  out  per-channel written-but-not-applied flag
//   clk_out      out  per-channel divided clock, 50% duty
//   tick         out  per-channel one-cycle pulse on the clk_out rise
module core_clkgen
    import core_clk_pkg::*;
#(
    parameter int                      NUM_CH  = 2,
    parameter int                      CNT_W   = CNT_W_DEF,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_DIV = {CNT_W'(PIPE_DIV), CNT_W'(SRAM_DIV)},
    localparam int                     CH_W    = ch_idx_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    // Each channel only sees a write strobe when the index matches it
    // exactly, so an index past the last channel reaches nobody.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic we_ch;

        assign we_ch = cfg_we && (cfg_ch == CH_W'(i));

        core_clkgen_ch #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (ch_en[i]),
            .sync    (sync),
            .we      (we_ch),
            .wdiv    (cfg_div),
            .pending (cfg_pending[i]),
            .clk_out (clk_out[i]),
            .tick    (tick[i])
        );
    end

endmodule
